// File: rtl/ttl_74194.sv
// WIDTH-bit universal shift register: hold, shift right, shift left or parallel load per rising Clk edge.
// One-edge latency, synchronous active-high Reset with priority over every mode, no backpressure.
module ttl_74194 #(
    parameter int WIDTH      = 4,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [1:0]       S,
    input  logic             DSR,
    input  logic             DSL,
    input  logic [WIDTH-1:0] P,
    output logic [WIDTH-1:0] Q
);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        logic shr_src;
        logic shl_src;
        logic stage_d;

        // End stages take the serial inputs in place of their missing neighbour.
        if (i == 0) begin : g_lo
            assign shr_src = DSR;
        end else begin : g_lo_mid
            assign shr_src = q_q[i-1];
        end

        if (i == WIDTH - 1) begin : g_hi
            assign shl_src = DSL;
        end else begin : g_hi_mid
            assign shl_src = q_q[i+1];
        end

        always_comb begin
            stage_d = 1'bx;
            case (S)
                MODE_HOLD: stage_d = q_q[i];
                MODE_SHR:  stage_d = shr_src;
                MODE_SHL:  stage_d = shl_src;
                MODE_LOAD: stage_d = P[i];
                default:   stage_d = 1'bx;
            endcase
        end

        assign q_d[i] = stage_d;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign #(DELAY_RISE, DELAY_FALL) Q = q_q;

endmodule

// File: tb/tb_ttl_74194.sv
// Scoreboard bench for ttl_74194 (WIDTH=4): expected Q pushed at drive time, popped after each edge.
module tb_ttl_74194;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [1:0] S = 2'b00;
    logic       DSR = 1'b0;
    logic       DSL = 1'b0;
    logic [3:0] P = 4'b0000;
    logic [3:0] Q;

    logic [3:0] sb[$];
    logic [3:0] m;
    logic [3:0] exp_q;
    int         n_chk = 0;
    int         n_fail = 0;

    ttl_74194 #(.WIDTH(4), .DELAY_RISE(0), .DELAY_FALL(0)) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .S    (S),
        .DSR  (DSR),
        .DSL  (DSL),
        .P    (P),
        .Q    (Q)
    );

    always #5 Clk = ~Clk;

    // Drive inputs on the falling edge, push the model's prediction, return 1 time unit after the rising edge.
    task automatic drive(input logic r, input logic [1:0] s, input logic dsr, input logic dsl,
                         input logic [3:0] p);
        @(negedge Clk);
        Reset = r; S = s; DSR = dsr; DSL = dsl; P = p;
        if (r) m = 4'b0000;
        else begin
            case (s)
                2'b00: m = m;
                2'b01: m = {m[2:0], dsr};
                2'b10: m = {dsl, m[3:1]};
                default: m = p;
            endcase
        end
        sb.push_back(m);
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 2'b11, 1'b0, 1'b0, 4'b1010);
        exp_q = sb.pop_front(); n_chk++;
        if (Q !== exp_q) begin n_fail++; $display("FAIL reset_preload: Q=%b expected %b", Q, exp_q); end
        drive(1'b1, 2'b11, 1'b1, 1'b1, 4'b1111);
        exp_q = sb.pop_front(); n_chk++;
        if (Q !== exp_q) begin n_fail++; $display("FAIL reset_clear: Q=%b expected %b", Q, exp_q); end
        drive(1'b0, 2'b00, 1'b1, 1'b1, 4'b1111);
        exp_q = sb.pop_front(); n_chk++;
        if (Q !== exp_q) begin n_fail++; $display("FAIL reset_hold: Q=%b expected %b", Q, exp_q); end
    endtask

    task automatic test_load_hold();
        drive(1'b0, 2'b11, 1'b0, 1'b0, 4'b1011);
        exp_q = sb.pop_front(); n_chk++;
        if (Q !== exp_q) begin n_fail++; $display("FAIL load: Q=%b expected %b", Q, exp_q); end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 2'b00, k[0], ~k[0], 4'b0000);
            // Glitch the data inputs between edges; only edge-sampled values may matter.
            #2; P = 4'b0101; DSR = 1'b1; DSL = 1'b1; S = 2'b11;
            #1; S = 2'b00;
            exp_q = sb.pop_front(); n_chk++;
            if (Q !== exp_q) begin n_fail++; $display("FAIL hold_%0d: Q=%b expected %b", k, Q, exp_q); end
        end
    endtask

    task automatic test_shift_right();
        logic [3:0] dsr_seq;
        dsr_seq = 4'b1101;  // applied LSB first: 1,0,1,1
        drive(1'b0, 2'b11, 1'b0, 1'b0, 4'b0000);
        exp_q = sb.pop_front(); n_chk++;
        if (Q !== exp_q) begin n_fail++; $display("FAIL shr_init: Q=%b expected %b", Q, exp_q); end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 2'b01, dsr_seq[k], 1'b0, 4'b1111);
            exp_q = sb.pop_front(); n_chk++;
            if (Q !== exp_q) begin n_fail++; $display("FAIL shr_%0d: Q=%b expected %b", k, Q, exp_q); end
        end
        n_chk++;
        if (Q !== 4'b1011) begin n_fail++; $display("FAIL shr_final: Q=%b expected %b", Q, 4'b1011); end
    endtask

    task automatic test_shift_left();
        drive(1'b0, 2'b11, 1'b0, 1'b0, 4'b1111);
        exp_q = sb.pop_front(); n_chk++;
        if (Q !== exp_q) begin n_fail++; $display("FAIL shl_init: Q=%b expected %b", Q, exp_q); end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 2'b10, 1'b1, (k == 2), 4'b0000);
            exp_q = sb.pop_front(); n_chk++;
            if (Q !== exp_q) begin n_fail++; $display("FAIL shl_%0d: Q=%b expected %b", k, Q, exp_q); end
        end
        n_chk++;
        if (Q !== 4'b1001) begin n_fail++; $display("FAIL shl_final: Q=%b expected %b", Q, 4'b1001); end
    endtask

    task automatic test_rotate();
        logic [3:0] ring[4];
        ring = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        drive(1'b0, 2'b11, 1'b0, 1'b0, 4'b0001);
        exp_q = sb.pop_front(); n_chk++;
        if (Q !== exp_q) begin n_fail++; $display("FAIL rot_init: Q=%b expected %b", Q, exp_q); end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 2'b01, Q[3], 1'b0, 4'b0000);
            exp_q = sb.pop_front(); n_chk++;
            if (Q !== exp_q || Q !== ring[k]) begin
                n_fail++; $display("FAIL rot_%0d: Q=%b expected %b", k, Q, ring[k]);
            end
        end
        drive(1'b0, 2'b10, 1'b0, Q[0], 4'b0000);
        exp_q = sb.pop_front(); n_chk++;
        if (Q !== exp_q || Q !== 4'b1000) begin
            n_fail++; $display("FAIL rot_left: Q=%b expected %b", Q, 4'b1000);
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b0, 2'b11, 1'b0, 1'b0, 4'b0011);
        exp_q = sb.pop_front(); n_chk++;
        if (Q !== exp_q) begin n_fail++; $display("FAIL mrst_load: Q=%b expected %b", Q, exp_q); end
        drive(1'b0, 2'b01, 1'b0, 1'b0, 4'b0000);
        exp_q = sb.pop_front(); n_chk++;
        if (Q !== exp_q || Q !== 4'b0110) begin
            n_fail++; $display("FAIL mrst_shift: Q=%b expected %b", Q, 4'b0110);
        end
        drive(1'b1, 2'b01, 1'b1, 1'b0, 4'b0000);
        exp_q = sb.pop_front(); n_chk++;
        if (Q !== exp_q) begin n_fail++; $display("FAIL mrst_clear: Q=%b expected %b", Q, exp_q); end
        drive(1'b0, 2'b01, 1'b1, 1'b0, 4'b0000);
        exp_q = sb.pop_front(); n_chk++;
        if (Q !== exp_q || Q !== 4'b0001) begin
            n_fail++; $display("FAIL mrst_resume: Q=%b expected %b", Q, 4'b0001);
        end
    endtask

    initial begin
        m = 4'bxxxx;
        test_reset();
        test_load_hold();
        test_shift_right();
        test_shift_left();
        test_rotate();
        test_mid_reset();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: left=%0d expected %0d", sb.size(), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
